// File: rtl/geofence_pkg.sv
// Shared geofence definitions: coordinate width, arbiter state encoding, id-width helper.
package geofence_pkg;

  localparam int COORD_W = 11;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // A single requester still needs a 1-bit id field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cross_mul_pipe.sv
// Two-stage signed cross product (ax*by - ay*bx) with valid/id tag passthrough.
// Latency 2 cycles, one result per cycle, no backpressure; CROSS_ZERO_FLAG_EN adds o_zero.
module cross_mul_pipe
  import geofence_pkg::*;
#(
  parameter int W    = COORD_W,
  parameter int ID_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic [ID_W-1:0]     i_id,
  input  logic signed [W-1:0] i_ax,
  input  logic signed [W-1:0] i_ay,
  input  logic signed [W-1:0] i_bx,
  input  logic signed [W-1:0] i_by,
  output logic                o_valid,
  output logic [ID_W-1:0]     o_id,
  output logic                o_pos
`ifdef CROSS_ZERO_FLAG_EN
  ,
  output logic                o_zero
`endif
);

  logic signed [2*W-1:0] w_ax_e;
  logic signed [2*W-1:0] w_ay_e;
  logic signed [2*W-1:0] w_bx_e;
  logic signed [2*W-1:0] w_by_e;
  logic signed [2*W-1:0] w_p1;
  logic signed [2*W-1:0] w_p2;
  logic signed [2*W-1:0] r_p1;
  logic signed [2*W-1:0] r_p2;
  logic [ID_W-1:0]       r_id1;
  logic                  r_v1;
  logic [2*W:0]          w_d;

  assign w_ax_e = {{W{i_ax[W-1]}}, i_ax};
  assign w_ay_e = {{W{i_ay[W-1]}}, i_ay};
  assign w_bx_e = {{W{i_bx[W-1]}}, i_bx};
  assign w_by_e = {{W{i_by[W-1]}}, i_by};

  // Each product of two W-bit values fits exactly in 2W signed bits.
  assign w_p1 = w_ax_e * w_by_e;
  assign w_p2 = w_ay_e * w_bx_e;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1  <= '0;
      r_p2  <= '0;
      r_id1 <= '0;
      r_v1  <= 1'b0;
    end else begin
      r_p1  <= w_p1;
      r_p2  <= w_p2;
      r_id1 <= i_id;
      r_v1  <= i_valid;
    end
  end

  // One extra bit keeps the difference exact at the operand extremes.
  assign w_d = {r_p1[2*W-1], r_p1} - {r_p2[2*W-1], r_p2};

  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_id    <= '0;
      o_pos   <= 1'b0;
    end else begin
      o_valid <= r_v1;
      o_id    <= r_id1;
      o_pos   <= ~w_d[2*W] & (|w_d);
    end
  end

`ifdef CROSS_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      o_zero <= 1'b0;
    end else begin
      o_zero <= ~(|w_d);
    end
  end
`endif

endmodule

// File: rtl/cross_engine_arbiter.sv
// Round-robin arbiter with burst lock sharing one cross-product engine; result 2 cycles after accept, no backpressure.
// Optional CROSS_ZERO_FLAG_EN adds rsp_zero (cross product exactly zero), registered with rsp_pos.
module cross_engine_arbiter
  import geofence_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int W        = COORD_W,
  parameter int LOCK_MAX = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           lock,
  input  logic [N_REQ*W-1:0]         opnd_ax,
  input  logic [N_REQ*W-1:0]         opnd_ay,
  input  logic [N_REQ*W-1:0]         opnd_bx,
  input  logic [N_REQ*W-1:0]         opnd_by,
  output logic [N_REQ-1:0]           gnt,
  output logic                       rsp_valid,
  output logic [id_width(N_REQ)-1:0] rsp_id,
  output logic                       rsp_pos
`ifdef CROSS_ZERO_FLAG_EN
  ,
  output logic                       rsp_zero
`endif
);

  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [ID_W-1:0]     r_owner;
  logic [ID_W-1:0]     w_owner_nxt;
  logic [CNT_W-1:0]    r_idle_cnt;
  logic [CNT_W-1:0]    w_idle_nxt;
  logic [N_REQ-1:0]    w_gnt;
  logic                w_accept;
  logic                w_acc_lock;
  logic [ID_W-1:0]     w_acc_id;
  logic [ID_W-1:0]     w_ptr_inc;
  logic signed [W-1:0] w_ax;
  logic signed [W-1:0] w_ay;
  logic signed [W-1:0] w_bx;
  logic signed [W-1:0] w_by;

  // Grant decode: owner-only while locked, rotating priority from r_ptr while open.
  always_comb begin
    int              v;
    logic            found;
    logic [ID_W-1:0] idx;
    w_gnt = '0;
    v     = 0;
    found = 1'b0;
    idx   = '0;
    if (!reset) begin
      if (r_state == ST_LOCKED) begin
        w_gnt[r_owner] = req[r_owner];
      end else begin
        for (int k = 0; k < N_REQ; k++) begin
          v = int'(r_ptr) + k;
          if (v >= N_REQ) v = v - N_REQ;
          idx = ID_W'(v);
          if (!found && req[idx]) begin
            w_gnt[idx] = 1'b1;
            found      = 1'b1;
          end
        end
      end
    end
  end

  assign gnt      = w_gnt;
  assign w_accept = |(w_gnt & req);

  always_comb begin
    w_acc_id   = '0;
    w_acc_lock = 1'b0;
    w_ax       = '0;
    w_ay       = '0;
    w_bx       = '0;
    w_by       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_acc_id   = ID_W'(i);
        w_acc_lock = lock[i];
        w_ax       = opnd_ax[i*W +: W];
        w_ay       = opnd_ay[i*W +: W];
        w_bx       = opnd_bx[i*W +: W];
        w_by       = opnd_by[i*W +: W];
      end
    end
  end

  assign w_ptr_inc = (int'(w_acc_id) == N_REQ - 1) ? '0 : w_acc_id + ID_W'(1);

  // While locked, r_ptr already points past the owner, so a timeout release leaves it untouched.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_idle_nxt  = r_idle_cnt;
    w_ptr_nxt   = r_ptr;
    if (w_accept) w_ptr_nxt = w_ptr_inc;
    case (r_state)
      ST_OPEN: begin
        if (w_accept && w_acc_lock) begin
          w_state_nxt = ST_LOCKED;
          w_owner_nxt = w_acc_id;
          w_idle_nxt  = '0;
        end
      end
      ST_LOCKED: begin
        if (w_accept) begin
          w_idle_nxt = '0;
          if (!w_acc_lock) w_state_nxt = ST_OPEN;
        end else if (r_idle_cnt == CNT_W'(LOCK_MAX - 1)) begin
          w_state_nxt = ST_OPEN;
          w_idle_nxt  = '0;
        end else begin
          w_idle_nxt = r_idle_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_OPEN;
        w_idle_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_OPEN;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_idle_cnt <= w_idle_nxt;
    end
  end

  cross_mul_pipe #(
    .W    (W),
    .ID_W (ID_W)
  ) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_accept),
    .i_id    (w_acc_id),
    .i_ax    (w_ax),
    .i_ay    (w_ay),
    .i_bx    (w_bx),
    .i_by    (w_by),
    .o_valid (rsp_valid),
    .o_id    (rsp_id),
    .o_pos   (rsp_pos)
`ifdef CROSS_ZERO_FLAG_EN
    ,
    .o_zero  (rsp_zero)
`endif
  );

endmodule

// File: tb/tb_cross_engine_arbiter.sv
// Bench for cross_engine_arbiter: directed scenarios with literal expectations plus randomized traffic vs a behavioural model.
`timescale 1ns/1ps
module tb_cross_engine_arbiter;

  localparam int N   = 4;
  localparam int W   = 11;
  localparam int LM  = 8;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] ax_v;
  logic [N*W-1:0] ay_v;
  logic [N*W-1:0] bx_v;
  logic [N*W-1:0] by_v;
  logic [N-1:0]   gnt;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic           rsp_pos;
`ifdef CROSS_ZERO_FLAG_EN
  logic           rsp_zero;
`endif

  cross_engine_arbiter #(
    .N_REQ    (N),
    .W        (W),
    .LOCK_MAX (LM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .opnd_ax   (ax_v),
    .opnd_ay   (ay_v),
    .opnd_bx   (bx_v),
    .opnd_by   (by_v),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_pos   (rsp_pos)
`ifdef CROSS_ZERO_FLAG_EN
    ,
    .rsp_zero  (rsp_zero)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: arbitration state in spec terms plus a queue of due responses.
  typedef struct {
    int due;
    int id;
    bit pos;
    bit zero;
  } rsp_t;

  rsp_t   q[$];
  int     cyc     = 0;
  bit     m_ready = 1'b0;
  bit     m_locked;
  int     m_ptr;
  int     m_owner;
  int     m_idle;

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    g = '0;
    if (reset) return g;
    if (m_locked) begin
      if (req[m_owner]) g[m_owner] = 1'b1;
      return g;
    end
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) begin
        g[(m_ptr + k) % N] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  logic [N-1:0] mg;
  int           mi;
  longint       md;
  rsp_t         mr;

  always @(posedge clk) begin
    mg = model_gnt();
    cyc++;
    if (reset) begin
      m_ready  = 1'b1;
      m_locked = 1'b0;
      m_ptr    = 0;
      m_owner  = 0;
      m_idle   = 0;
      q.delete();
    end else if (m_ready) begin
      if (mg != '0) begin
        mi = 0;
        for (int i = 0; i < N; i++) if (mg[i]) mi = i;
        md = longint'(sx(ax_v[mi*W +: W])) * longint'(sx(by_v[mi*W +: W]))
           - longint'(sx(ay_v[mi*W +: W])) * longint'(sx(bx_v[mi*W +: W]));
        mr.due  = cyc + 1;
        mr.id   = mi;
        mr.pos  = (md > 0);
        mr.zero = (md == 0);
        q.push_back(mr);
        m_ptr = (mi + 1) % N;
        if (!m_locked) begin
          if (lock[mi]) begin
            m_locked = 1'b1;
            m_owner  = mi;
            m_idle   = 0;
          end
        end else if (lock[mi]) begin
          m_idle = 0;
        end else begin
          m_locked = 1'b0;
        end
      end else if (m_locked) begin
        m_idle++;
        if (m_idle >= LM) begin
          m_locked = 1'b0;
          m_idle   = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("gnt", int'(gnt), int'(model_gnt()));
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("rsp_valid", int'(rsp_valid), 1);
        chk("rsp_id", int'(rsp_id), q[0].id);
        chk("rsp_pos", int'(rsp_pos), int'(q[0].pos));
`ifdef CROSS_ZERO_FLAG_EN
        chk("rsp_zero", int'(rsp_zero), int'(q[0].zero));
`endif
        q.delete(0);
      end else begin
        chk("rsp_valid_idle", int'(rsp_valid), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int ax, input int ay, input int bx, input int by);
    ax_v[i*W +: W] = W'(ax);
    ay_v[i*W +: W] = W'(ay);
    bx_v[i*W +: W] = W'(bx);
    by_v[i*W +: W] = W'(by);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    lock  = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic one_shot(input string name, input int i, input int ax, input int ay,
                          input int bx, input int by, input int exp_pos, input int exp_zero);
    req  = N'(1) << i;
    lock = '0;
    set_op(i, ax, ay, bx, by);
    tick();
    req = '0;
    tick();
    @(negedge clk);
    chk({name, "_valid"}, int'(rsp_valid), 1);
    chk({name, "_id"}, int'(rsp_id), i);
    chk({name, "_pos"}, int'(rsp_pos), exp_pos);
`ifdef CROSS_ZERO_FLAG_EN
    chk({name, "_zero"}, int'(rsp_zero), exp_zero);
`else
    if (exp_zero < 0) chk({name, "_zero_arg"}, exp_zero, 0);
`endif
  endtask

  int pr;
  int pl;
  int v;

  initial begin
    reset = 1'b1;
    req   = '1;
    lock  = '0;
    ax_v  = '0;
    ay_v  = '0;
    bx_v  = '0;
    by_v  = '0;
    tick();
    @(negedge clk);
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_id", int'(rsp_id), 0);
    chk("reset_rsp_pos", int'(rsp_pos), 0);
    tick();
    reset = 1'b0;
    req   = '0;

    one_shot("single_pos", 0, 3, 0, 0, 4, 1, 0);
    one_shot("single_neg", 0, 0, 4, 3, 0, 0, 0);
    one_shot("extreme", 0, -1024, 1023, -1024, -1024, 1, 0);
    one_shot("parallel", 0, 5, 5, 10, 10, 0, 1);
    one_shot("req3_neg", 3, -7, 2, 9, -1, 0, 0);

    do_reset();
    req = '1;
    for (int k = 0; k < 8; k++) begin
      set_op(k % N, k, 1, -1, k);
      @(negedge clk);
      chk("rr_gnt", int'(gnt), 1 << (k % N));
      tick();
    end
    req = '0;
    tick();
    tick();

    do_reset();
    req = 4'b0001;
    tick();
    req  = '1;
    lock = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) lock = '0;
      @(negedge clk);
      chk("burst_gnt", int'(gnt), 2);
      tick();
    end
    @(negedge clk);
    chk("burst_after", int'(gnt), 4);
    tick();
    req = '0;

    do_reset();
    req  = 4'b0100;
    lock = 4'b0100;
    @(negedge clk);
    chk("tmo_first", int'(gnt), 4);
    tick();
    req  = 4'b1000;
    lock = '0;
    for (int k = 0; k < LM; k++) begin
      @(negedge clk);
      chk("tmo_hold", int'(gnt), 0);
      tick();
    end
    @(negedge clk);
    chk("tmo_release", int'(gnt), 8);
    tick();
    req = '0;

    do_reset();
    req = 4'b0001;
    set_op(0, 1, 0, 0, 1);
    tick();
    req   = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = '1;
    @(negedge clk);
    chk("midrst_valid", int'(rsp_valid), 0);
    chk("midrst_ptr0", int'(gnt), 1);
    tick();
    req = '0;
    tick();
    tick();

    for (int c = 0; c < 3000; c++) begin
      pr = (c / 500) % 3 == 0 ? 30 : ((c / 500) % 3 == 1 ? 60 : 90);
      pl = (c / 300) % 3 == 0 ? 0 : ((c / 300) % 3 == 1 ? 40 : 85);
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        req[i]  = ($urandom_range(0, 99) < pr);
        lock[i] = ($urandom_range(0, 99) < pl);
        case ($urandom_range(0, 7))
          0: set_op(i, -1024, 1023, -1024, -1024);
          1: begin
            v = int'($urandom_range(0, 2047)) - 1024;
            set_op(i, v, 1023, v, 1023);
          end
          2: set_op(i, 1023, -1024, -1024, 1023);
          default: set_op(i, int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024,
                          int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024);
        endcase
      end
      tick();
    end
    reset = 1'b0;
    req   = '0;
    lock  = '0;
    for (int k = 0; k < 4; k++) tick();
    if (q.size() != 0) chk("drain_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cross_engine_arbiter.md
Name: cross_engine_arbiter

Overview:
- Owns one shared pipelined 2-D cross-product engine (ax*by − ay*bx, sign result) and shares it between up to N_REQ requesters, such as point-in-polygon testers and vertex sorters.
- Round-robin arbitration.
- A lock mechanism lets one requester hold the engine for a burst, e.g. the six edge tests of one hexagon fence.
- Returns the sign result tagged with the requester id.

Parameters:
N_REQ, 4, number of requesters (1..8)
W, 11, signed operand width (two's complement, range −1024..1023)
LOCK_MAX, 8, consecutive idle cycles of a lock owner before its lock is force-released (≥1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req  in  N_REQ  per-requester request
lock  in  N_REQ  per-requester: keep grant after this transaction
opnd_ax  in  N_REQ*W  vector A x; slice i belongs to requester i
opnd_ay  in  N_REQ*W  vector A y
opnd_bx  in  N_REQ*W  vector B x
opnd_by  in  N_REQ*W  vector B y
gnt  out  N_REQ  one-hot grant, combinational
rsp_valid  out  1  result valid, one cycle
rsp_id  out  clog2(N_REQ) (min 1)  requester index of result
rsp_pos  out  1  1 when cross product > 0 (strict)

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous, active-high.
- Reset values:
  - ptr=0, state OPEN, owner=0, idle_cnt=0, pipeline valids=0.
  - rsp_valid=0, rsp_id=0, rsp_pos=0.
  - gnt forced to 0 while reset is high.
- Accept: requester i is accepted in a cycle where req[i]&&gnt[i]. Its operand slices and lock[i] are sampled at that edge. At most one accept per cycle.
- gnt decode, state OPEN:
  - Grant goes to the first i with req[i]=1, searching ptr, ptr+1, … mod N_REQ.
  - gnt=0 if no request.
- gnt decode, state LOCKED: gnt[owner]=req[owner]; all other grants are 0.
- ptr update: on every accept of i, ptr ← (i+1) mod N_REQ. ptr holds when there is no accept.
- OPEN → LOCKED: accept of i with lock[i]=1. Then owner←i, idle_cnt←0.
- LOCKED → LOCKED:
  - Accept with lock=1 keeps the lock and clears idle_cnt.
  - A cycle with req[owner]=0 increments idle_cnt.
- LOCKED → OPEN, either of:
  - Accept with lock=0. That result is still issued.
  - idle_cnt reaches LOCK_MAX. The release takes effect at that edge, so arbitration in the next cycle is OPEN with ptr=owner+1.
- Engine, stage 1 (registered):
  - p1=ax*by, p2=ay*bx; each is 2W-bit signed.
  - Registered alongside: id, v1.
- Engine, stage 2 (registered):
  - d=p1−p2 computed at 2W+1 bits (no overflow at operand extremes).
  - rsp_pos←(d>0), rsp_id←id, rsp_valid←v1.
- Latency and throughput:
  - rsp_valid is asserted exactly 2 cycles after the accept edge.
  - Throughput is 1 result per cycle; no backpressure.
  - Results return in accept order.
- d=0 gives rsp_pos=0.
- Reset mid-operation: all in-flight transactions are dropped (no rsp_valid), and any lock is released.
- N_REQ=1: gnt=req; lock still tracked.
- A requester whose req deasserts before it is granted is simply not served. No request queueing.

Optional Feature:
- Macro: CROSS_ZERO_FLAG_EN.
- Defined: adds output port rsp_zero (1 bit), which is 1 when d==0. It is registered with rsp_pos, reset value 0.
- Undefined: the port and its logic are absent; rsp_pos behaviour is unchanged.

Decomposition:
- Shared package geofence_pkg holds:
  - the coordinate width constant (11);
  - the arbiter state encoding (OPEN, LOCKED);
  - the id-width helper.
- One sub-module, cross_mul_pipe: the 2-stage signed cross-product pipeline with a valid/id tag passthrough. The arbiter instantiates it once.

Test Plan:
- Single requester: req0, a=(3,0), b=(0,4) → 2 cycles later rsp_valid=1, rsp_id=0, rsp_pos=1; then swap a and b → rsp_pos=0.
- Width extremes: a=(−1024,1023), b=(−1024,−1024) → d=2096128, rsp_pos=1. Then a=(5,5), b=(10,10) → rsp_pos=0 (and rsp_zero=1 when CROSS_ZERO_FLAG_EN is defined).
- Round-robin fairness: req=4'b1111 held, no locks → gnt sequence 0,1,2,3,0,… in consecutive cycles; rsp_id follows the same order, lagged by 2.
- Lock burst: req=1111 with req1 first granted and lock1=1 for 5 accepts, then lock1=0 on the 6th → gnt only to requester 1 for 6 cycles, then the next grant goes to requester 2.
- Lock timeout, LOCK_MAX=8: requester 2 accepted with lock=1, then req2=0 while req3=1 → gnt3 stays 0 for 8 cycles, then gnt3=1 in the following cycle.
- Reset mid-pipeline: accept at cycle t, reset=1 at t+1 → no rsp_valid at t+2; state OPEN, ptr=0 afterwards.
